// File: rtl/stim_seq_pkg.sv
// -----------------------------------------------------------------------------
// stim_seq_pkg
// Shared types, default constants and pure helper functions for the stimulus
// sequencer: the FSM state encoding, the default LFSR/MISR polynomials and
// MISR seed, and single-step LFSR / MISR update functions.
// No ports (package).
// -----------------------------------------------------------------------------
package stim_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [31:0] LFSR_POLY_DEF = 32'h80200003;
    localparam logic [31:0] MISR_POLY_DEF = 32'h04C11DB7;
    localparam logic [31:0] MISR_INIT_DEF = 32'hFFFFFFFF;

    // Right-shifting Galois LFSR: the bit shifted out decides whether the
    // feedback mask is applied.
    function automatic logic [31:0] lfsr_step(input logic [31:0] l,
                                              input logic [31:0] poly);
        logic [31:0] nxt;
        nxt = l >> 1;
        if (l[0]) begin
            nxt = nxt ^ poly;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    // Left-shifting MISR with the folded response XORed into the shifted value.
    function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                              input logic [31:0] fold,
                                              input logic [31:0] poly);
        logic [31:0] nxt;
        nxt = {sig[30:0], 1'b0};
        if (sig[31]) begin
            nxt = nxt ^ poly;
        end else begin
            nxt = nxt;
        end
        return nxt ^ fold;
    endfunction

endpackage

// File: rtl/stim_misr32.sv
// -----------------------------------------------------------------------------
// stim_misr32
// 32-bit multiple-input signature register. Reloads INIT on reset or init,
// otherwise absorbs one folded response word per enabled cycle.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset (signature -> INIT)
//   init  in   synchronous reload of INIT (has priority over en)
//   en    in   absorb fold this cycle
//   fold  in   32-bit folded response word
//   sig   out  current signature (registered)
// -----------------------------------------------------------------------------
module stim_misr32
    import stim_seq_pkg::*;
#(
    parameter logic [31:0] POLY = MISR_POLY_DEF,
    parameter logic [31:0] INIT = MISR_INIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [31:0] fold,
    output logic [31:0] sig
);

    logic [31:0] sig_r;

    // Signature register: reload on init, compact on enable, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_r <= INIT;
        end else if (init) begin
            sig_r <= INIT;
        end else if (en) begin
            sig_r <= misr_step(sig_r, fold, POLY);
        end else begin
            sig_r <= sig_r;
        end
    end

    assign sig = sig_r;

endmodule

// File: rtl/stim_sequencer.sv
// -----------------------------------------------------------------------------
// stim_sequencer
// Drives pseudo-random 96-bit vectors (three 32-bit LFSR steps per vector)
// into a combinational datapath, waits SETTLE_CYCLES, then compacts the
// 96-bit response into a 32-bit MISR signature. A start/busy/done handshake
// frames each run of num_vec_i vectors.
//
// Optional feature macro: STIM_SIG_CHECK_EN
//   When defined, adds expected_sig_i (captured on start) and pass_o, which
//   reports final signature == expected after DONE and is cleared by start.
//
// Ports:
//   clkin_data      in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   start_i         in   begin a run (sampled only in IDLE)
//   seed_i   [31:0] in   LFSR seed (0 is replaced by 1)
//   num_vec_i[15:0] in   vectors per run
//   in_data_o[95:0] out  vector to datapath
//   out_data_i[95:0]in   datapath response
//   busy_o          out  run in progress (through the DONE cycle)
//   done_o          out  one-cycle completion pulse
//   vec_cnt_o[15:0] out  vectors captured in current/last run
//   sig_o    [31:0] out  current/final signature
//   expected_sig_i  in   (STIM_SIG_CHECK_EN) expected final signature
//   pass_o          out  (STIM_SIG_CHECK_EN) signature check result
// -----------------------------------------------------------------------------
module stim_sequencer
    import stim_seq_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] LFSR_POLY     = LFSR_POLY_DEF,
    parameter logic [31:0] MISR_POLY     = MISR_POLY_DEF,
    parameter logic [31:0] MISR_INIT     = MISR_INIT_DEF
) (
    input  logic        clkin_data,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] seed_i,
    input  logic [15:0] num_vec_i,
    output logic [95:0] in_data_o,
    input  logic [95:0] out_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] vec_cnt_o,
    output logic [31:0] sig_o
`ifdef STIM_SIG_CHECK_EN
    ,
    input  logic [31:0] expected_sig_i,
    output logic        pass_o
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_r,   state_nxt_s;
    logic [1:0]  lane_r,    lane_nxt_s;
    logic [3:0]  settle_r,  settle_nxt_s;
    logic [31:0] lfsr_r,    lfsr_nxt_s;
    logic [95:0] in_data_r, in_data_nxt_s;
    logic [15:0] vec_cnt_r, vec_cnt_nxt_s;
    logic [15:0] num_vec_r, num_vec_nxt_s;
    logic        busy_r,    busy_nxt_s;
    logic        done_r,    done_nxt_s;
    logic        misr_init_s;
    logic        misr_en_s;
    logic [31:0] lfsr_step_s;
    logic [31:0] fold_s;
    logic [31:0] sig_s;

    assign lfsr_step_s = lfsr_step(lfsr_r, LFSR_POLY);
    assign fold_s      = out_data_i[31:0] ^ out_data_i[63:32] ^ out_data_i[95:64];

    // State register.
    always_ff @(posedge clkin_data or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and next values of all datapath registers.
    always_comb begin
        state_nxt_s   = state_r;
        lane_nxt_s    = lane_r;
        settle_nxt_s  = settle_r;
        lfsr_nxt_s    = lfsr_r;
        in_data_nxt_s = in_data_r;
        vec_cnt_nxt_s = vec_cnt_r;
        num_vec_nxt_s = num_vec_r;
        misr_init_s   = 1'b0;
        misr_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    num_vec_nxt_s = num_vec_i;
                    // An all-zero seed would lock the LFSR at zero.
                    lfsr_nxt_s    = (seed_i == 32'd0) ? 32'd1 : seed_i;
                    misr_init_s   = 1'b1;
                    vec_cnt_nxt_s = 16'd0;
                    lane_nxt_s    = 2'd0;
                    if (num_vec_i == 16'd0) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                lfsr_nxt_s = lfsr_step_s;
                case (lane_r)
                    2'd0:    in_data_nxt_s[31:0]  = lfsr_step_s;
                    2'd1:    in_data_nxt_s[63:32] = lfsr_step_s;
                    2'd2:    in_data_nxt_s[95:64] = lfsr_step_s;
                    default: in_data_nxt_s        = in_data_r;
                endcase
                if (lane_r == 2'd2) begin
                    lane_nxt_s   = 2'd0;
                    settle_nxt_s = 4'd0;
                    state_nxt_s  = ST_SETTLE;
                end else begin
                    lane_nxt_s   = lane_r + 2'd1;
                end
            end
            ST_SETTLE: begin
                if (settle_r == SETTLE_LAST) begin
                    state_nxt_s  = ST_CAPTURE;
                end else begin
                    settle_nxt_s = settle_r + 4'd1;
                end
            end
            ST_CAPTURE: begin
                misr_en_s     = 1'b1;
                vec_cnt_nxt_s = vec_cnt_r + 16'd1;
                // num_vec_r is non-zero here, so the incremented count
                // reaches it before it could wrap.
                if ((vec_cnt_r + 16'd1) == num_vec_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    lane_nxt_s  = 2'd0;
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // busy/done are registered alongside the state they describe.
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // Datapath and handshake registers.
    always_ff @(posedge clkin_data or posedge rst) begin
        if (rst) begin
            lane_r    <= 2'd0;
            settle_r  <= 4'd0;
            lfsr_r    <= 32'd1;
            in_data_r <= 96'd0;
            vec_cnt_r <= 16'd0;
            num_vec_r <= 16'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            lane_r    <= lane_nxt_s;
            settle_r  <= settle_nxt_s;
            lfsr_r    <= lfsr_nxt_s;
            in_data_r <= in_data_nxt_s;
            vec_cnt_r <= vec_cnt_nxt_s;
            num_vec_r <= num_vec_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    stim_misr32 #(
        .POLY (MISR_POLY),
        .INIT (MISR_INIT)
    ) u_misr (
        .clk  (clkin_data),
        .rst  (rst),
        .init (misr_init_s),
        .en   (misr_en_s),
        .fold (fold_s),
        .sig  (sig_s)
    );

    assign in_data_o = in_data_r;
    assign busy_o    = busy_r;
    assign done_o    = done_r;
    assign vec_cnt_o = vec_cnt_r;
    assign sig_o     = sig_s;

`ifdef STIM_SIG_CHECK_EN
    logic [31:0] exp_sig_r;
    logic        pass_r;

    // Expected-signature capture and pass flag; sig_s is final during DONE.
    always_ff @(posedge clkin_data or posedge rst) begin
        if (rst) begin
            exp_sig_r <= 32'd0;
            pass_r    <= 1'b0;
        end else if ((state_r == ST_IDLE) && start_i) begin
            exp_sig_r <= expected_sig_i;
            pass_r    <= 1'b0;
        end else if (state_r == ST_DONE) begin
            exp_sig_r <= exp_sig_r;
            pass_r    <= (sig_s == exp_sig_r);
        end else begin
            exp_sig_r <= exp_sig_r;
            pass_r    <= pass_r;
        end
    end

    assign pass_o = pass_r;
`endif

endmodule
